// File: rtl/updown_sweep_sequencer_if.sv
// updown_sweep_sequencer_if: button inputs and display-datapath outputs of the sweep sequencer
interface updown_sweep_sequencer_if #(parameter int WIDTH = 4);
  logic start, progressive, regressive, pause;
  logic [WIDTH-1:0] count;
  logic dir_up, running, sweep_done;
  logic [2:0] state;
  modport master (output start, progressive, regressive, pause, input count, dir_up, running, sweep_done, state);
  modport slave (input start, progressive, regressive, pause, output count, dir_up, running, sweep_done, state);
endinterface

// File: rtl/updown_sweep_sequencer.sv
// updown_sweep_sequencer: prescaled up/down sweep counter with hold, pause and button edge detection
module updown_sweep_sequencer #(
  parameter int WIDTH = 4,
  parameter int MAX_VAL = 9,
  parameter int TICK_DIV = 100_000_000,
  parameter int CYCLES = 1
) (
  input logic clk,
  input logic reset_n,
  updown_sweep_sequencer_if.slave bus
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = CYCLES > 0 ? $clog2(CYCLES + 1) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, UP = 3'd1, DOWN = 3'd2, HOLD = 3'd3, PAUSED = 3'd4} state_t;
  state_t r_state, w_state, r_ret, w_ret;
  logic [WIDTH-1:0] r_count, w_count;
  logic [PW-1:0] r_pre, w_pre;
  logic [SW-1:0] r_sweep, w_sweep, w_sweep_inc;
  logic r_dir, r_running, r_done, w_done, w_tick;
  logic [3:0] r_s1, r_s2, r_prev, w_edge;
  assign w_edge = r_s2 & ~r_prev;
  assign w_tick = r_pre == PW'(TICK_DIV - 1);
  assign w_sweep_inc = &r_sweep ? r_sweep : r_sweep + 1'b1;
  always_comb begin
    w_state = r_state;
    w_ret = r_ret;
    w_count = r_count;
    w_pre = r_pre;
    w_sweep = r_sweep;
    w_done = 1'b0;
    case (r_state)
      IDLE: if (w_edge[0]) begin
        w_state = UP;
        w_count = '0;
        w_pre = '0;
        w_sweep = '0;
      end
      UP, DOWN: if (w_edge[3]) begin
        w_state = PAUSED;
        w_ret = r_state;
      end else begin
        w_pre = w_tick ? '0 : r_pre + 1'b1;
        if (w_tick && r_state == UP) begin
          if (r_count == WIDTH'(MAX_VAL)) begin
            w_state = DOWN;
            w_count = WIDTH'(MAX_VAL - 1);
          end else w_count = r_count + 1'b1;
        end else if (w_tick) begin
          if (r_count != '0) w_count = r_count - 1'b1;
          else begin
            w_sweep = w_sweep_inc;
            if (CYCLES != 0 && w_sweep_inc == SW'(CYCLES)) begin
              w_state = HOLD;
              w_done = 1'b1;
            end else begin
              w_state = UP;
              w_count = WIDTH'(1);
            end
          end
        end
      end
      HOLD: if (w_edge[2] || w_edge[1]) begin
        w_state = w_edge[2] ? UP : DOWN;
        w_count = w_edge[2] ? '0 : WIDTH'(MAX_VAL);
        w_pre = '0;
        w_sweep = '0;
      end
      PAUSED: if (w_edge[3]) w_state = r_ret;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_ret <= IDLE;
      r_count <= '0;
      r_pre <= '0;
      r_sweep <= '0;
      r_dir <= 1'b1;
      r_running <= 1'b0;
      r_done <= 1'b0;
      r_s1 <= '0;
      r_s2 <= '0;
      r_prev <= '0;
    end else begin
      r_s1 <= {bus.pause, bus.progressive, bus.regressive, bus.start};
      r_s2 <= r_s1;
      r_prev <= r_s2;
      r_state <= w_state;
      r_ret <= w_ret;
      r_count <= w_count;
      r_pre <= w_pre;
      r_sweep <= w_sweep;
      r_dir <= w_state == UP ? 1'b1 : w_state == DOWN ? 1'b0 : r_dir;
      r_running <= w_state == UP || w_state == DOWN;
      r_done <= w_done;
    end
  end
  assign bus.count = r_count;
  assign bus.dir_up = r_dir;
  assign bus.running = r_running;
  assign bus.sweep_done = r_done;
  assign bus.state = r_state;
endmodule
